// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared pipeline encodings for the EX/MEM boundary
package ex_mem_reg_pkg;

  typedef enum logic [1:0] {
    LD_NONE = 2'b00,
    LD_LB   = 2'b01,
    LD_LH   = 2'b10,
    LD_LW   = 2'b11
  } load_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_e;

  localparam logic [3:0] WEN_NONE  = 4'b0000;
  localparam logic [3:0] WEN_SB    = 4'b0001;
  localparam logic [3:0] WEN_SH_LO = 4'b0011;
  localparam logic [3:0] WEN_SH_HI = 4'b1100;
  localparam logic [3:0] WEN_SW    = 4'b1111;

  // Load and store codes share the size encoding: 01 byte, 10 half, 11 word.
  function automatic logic misaligned(input logic [1:0] size_code,
                                      input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size_code)
      2'b10:   bad = offset[0];
      2'b11:   bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - byte-enable generation and store data replication
module store_align
  import ex_mem_reg_pkg::*;
(
  input  logic [1:0]  memW,
  input  logic [1:0]  offset,
  input  logic [31:0] rt_data,
  input  logic        en,
  output logic [3:0]  wen,
  output logic [31:0] wdata
);

  always_comb begin
    wen   = WEN_NONE;
    wdata = rt_data;
    case (memW)
      ST_SB: begin
        wdata = {4{rt_data[7:0]}};
        if (en) wen = WEN_SB << offset;
      end
      ST_SH: begin
        wdata = {2{rt_data[15:0]}};
        if (en) wen = offset[1] ? WEN_SH_HI : WEN_SH_LO;
      end
      ST_SW: begin
        wdata = rt_data;
        if (en) wen = WEN_SW;
      end
      default: begin
        wen   = WEN_NONE;
        wdata = rt_data;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with data SRAM request issue
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        zero,
  input  logic [1:0]  memR,
  input  logic [1:0]  memW,
  input  logic [31:0] Aluout,
  input  logic [31:0] rt_data,
  input  logic [4:0]  rd,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic        Branch_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic        zero_o,
  output logic [1:0]  memR_o,
  output logic [31:0] Aluout_o,
  output logic [4:0]  rd_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic accept;
  logic adel;
  logic ades;
  logic addr_err;

  assign accept   = ex_valid & ~stall & ~flush;
  assign adel     = misaligned(memR, Aluout[1:0]);
  assign ades     = misaligned(memW, Aluout[1:0]);
  assign addr_err = adel | ades;

  // Request only on the accepting cycle, so a held store never writes twice.
  assign data_sram_en   = ~reset & accept & ((memR != LD_NONE) | (memW != ST_NONE)) & ~addr_err;
  assign data_sram_addr = {Aluout[31:2], 2'b00};

  store_align u_store_align (
    .memW    (memW),
    .offset  (Aluout[1:0]),
    .rt_data (rt_data),
    .en      (data_sram_en),
    .wen     (data_sram_wen),
    .wdata   (data_sram_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !ex_valid)) begin
      mem_valid  <= 1'b0;
      Branch_o   <= 1'b0;
      MemtoReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
      zero_o     <= 1'b0;
      memR_o     <= 2'b00;
      Aluout_o   <= 32'd0;
      rd_o       <= 5'd0;
      adel_o     <= 1'b0;
      ades_o     <= 1'b0;
    end else if (accept) begin
      // A faulting access still travels down as valid so the exception is taken in MEM.
      mem_valid  <= 1'b1;
      Branch_o   <= Branch;
      MemtoReg_o <= MemtoReg;
      RegWrite_o <= RegWrite & ~addr_err;
      zero_o     <= zero;
      memR_o     <= addr_err ? 2'b00 : memR;
      Aluout_o   <= Aluout;
      rd_o       <= rd;
      adel_o     <= adel;
      ades_o     <= ades;
    end
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit data/address, 5-bit register index).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_valid  in  1  EX stage holds a live instruction.
REQ-005 Branch, MemtoReg, RegWrite, zero  in  1 each  EX control/flag bits.
REQ-006 memR  in  2  load type: 00 none, 01 lb, 10 lh, 11 lw.
REQ-007 memW  in  2  store type: 00 none, 01 sb, 10 sh, 11 sw.
REQ-008 Aluout  in  32  effective address or ALU result.
REQ-009 rt_data  in  32  store source register value.
REQ-010 rd  in  5  destination register index.
REQ-011 stall  in  1  hold MEM-side register contents.
REQ-012 flush  in  1  kill the instruction entering MEM.
REQ-013 mem_valid, Branch_o, MemtoReg_o, RegWrite_o, zero_o  out  1 each  registered to MEM stage.
REQ-014 memR_o  out  2; Aluout_o  out  32; rd_o  out  5  registered to MEM stage.
REQ-015 adel_o, ades_o  out  1 each  registered load/store address-error flags.
REQ-016 data_sram_en  out  1; data_sram_wen  out  4; data_sram_addr  out  32; data_sram_wdata  out  32  combinational SRAM request.

Function
REQ-017 Accept condition: accept = ex_valid & ~stall & ~flush.
REQ-018 Address error: adel = lh & Aluout[0], or lw & Aluout[1:0]!=00; ades likewise for sh/sw; lb/sb never error.
REQ-019 data_sram_en SHALL be 1 only when accept and (memR!=00 or memW!=00) and no adel/ades.
REQ-020 data_sram_addr SHALL equal {Aluout[31:2],2'b00}.
REQ-021 data_sram_wen SHALL be 0000 unless data_sram_en and memW!=00; sb: one-hot bit Aluout[1:0]; sh: 0011 at offset 00, 1100 at offset 10; sw: 1111.
REQ-022 data_sram_wdata: sb replicates rt_data[7:0] to all four bytes; sh replicates rt_data[15:0] to both halves; sw passes rt_data.
REQ-023 Each store SHALL write the SRAM exactly once, regardless of how many stall cycles follow.
REQ-024 Latency: outputs *_o SHALL reflect EX inputs one cycle after the accepting edge, aligned with the synchronous SRAM read data.
REQ-025 stall=1 and flush=0: all *_o registers hold; no SRAM request issued.
REQ-026 flush=1, stall ignored: next edge SHALL set mem_valid=0 and RegWrite_o, Branch_o, MemtoReg_o, memR_o, adel_o, ades_o=0.
REQ-027 ex_valid=0 without stall: next edge SHALL load a bubble, as in REQ-026.
REQ-028 Error case: accepted instruction with adel or ades SHALL register mem_valid=1, the flag, Aluout_o=faulting address, RegWrite_o=0, memR_o=00.

Reset
REQ-029 reset=1 at an edge SHALL clear every registered output to 0, overriding stall and flush.
REQ-030 During reset cycles data_sram_en and data_sram_wen SHALL be 0.
REQ-031 Reset mid-stall SHALL discard the held instruction; no store is replayed after release.

Structure
REQ-032 memR/memW encodings and the wen patterns SHALL live in the shared pipeline package.
REQ-033 Byte-enable and write-data replication SHALL be one sub-module, store_align (combinational), instantiated once.

Verification
REQ-034 sw, Aluout=0x0000_1004, rt_data=0xDEADBEEF -> en=1, wen=1111, addr=0x1004, wdata=0xDEADBEEF; next cycle mem_valid=1.
REQ-035 sb, Aluout=0x0000_2003, rt_data=0x0000_00A5 -> wen=1000, wdata=0xA5A5A5A5.
REQ-036 lw, Aluout=0x0000_3002 -> en=0, next cycle adel_o=1, Aluout_o=0x3002, RegWrite_o=0.
REQ-037 sh at 0x0000_4002 followed by stall for 3 cycles -> wen=1100 for exactly one cycle; *_o held for 3 cycles.
REQ-038 stall=1 and flush=1 together with lw valid -> next cycle mem_valid=0, RegWrite_o=0, en=0.
REQ-039 reset asserted during stall with stored sb held -> all outputs 0; after release no write occurs.
